mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the RV32I pipeline, sitting on the consumer side of the EX/MEM pipeline register. It takes the registered memory-control bundle and runs a req/gnt/rvalid data-memory transaction. It stalls the pipeline until the access completes, then presents aligned, sign- or zero-extended load data to the MEM/WB path.

---
 rtl/mem_lsu_pkg.sv | 29 ++
 rtl/mem_lsu_if.sv | 18 +
 rtl/mem_lsu_align.sv | 47 ++++
 rtl/mem_lsu.sv | 145 ++++++++++++++
 tb/tb_mem_lsu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   lsu_state_e     : transaction FSM states
//   BYTE_NUM_B/H/W  : access-size encodings carried on byte_num
//   WB_SEL_LOAD     : write-back select value that marks a load
//   align_off()     : byte offset with the low bits forced to the access size
//   is_misaligned() : half/word access whose offset is not naturally aligned
package mem_lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [3:0] BYTE_NUM_B  = 4'b0001;
  localparam logic [3:0] BYTE_NUM_H  = 4'b0011;
  localparam logic [3:0] BYTE_NUM_W  = 4'b1111;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;

  function automatic logic [1:0] align_off(input logic [3:0] byte_num, input logic [1:0] off);
    case (byte_num)
      BYTE_NUM_W: align_off = 2'b00;
      BYTE_NUM_H: align_off = {off[1], 1'b0};
      default:    align_off = off;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] byte_num, input logic [1:0] off);
    is_misaligned = ((byte_num == BYTE_NUM_H) && off[0]) ||
                    ((byte_num == BYTE_NUM_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/gnt/rvalid data-memory bus.
//   master (LSU)   drives req, we, addr (word aligned), be, wdata
//   slave (memory) drives gnt, rvalid, rdata
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane logic for the LSU.
//   st_byte_num/st_off/st_wdata -> be, lane_wdata (store byte enables and
//                                  lane-replicated store data)
//   ld_byte_num/ld_off/ld_unsigned/rdata -> ld_data (right-aligned, masked,
//                                  sign- or zero-extended load result)
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  st_byte_num,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [3:0]  ld_byte_num,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [31:0]               sh;

  assign be = st_byte_num << st_off;

  // Every lane carries the byte that would land there for any legal offset,
  // so the memory only needs the byte enables to pick the right ones.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes[i] = (st_byte_num == BYTE_NUM_B) ? st_wdata[7:0] :
                      (st_byte_num == BYTE_NUM_H) ? st_wdata[(i%2)*8 +: 8] :
                                                    st_wdata[i*8 +: 8];
  end
  assign lane_wdata = lanes;

  assign sh = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = sh;
    case (ld_byte_num)
      BYTE_NUM_B: ld_data = {{24{sh[7]  & ~ld_unsigned}}, sh[7:0]};
      BYTE_NUM_H: ld_data = {{16{sh[15] & ~ld_unsigned}}, sh[15:0]};
      default:    ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Runs one req/gnt/rvalid transaction per
// memory op from the EX/MEM register and stalls upstream until it completes.
//   clk_i, synclr_i          : clock, synchronous active-high reset
//   valid_i, wb_sel_i,
//   mem_wren_i, byte_num_i,
//   ld_unsigned_i, addr_i,
//   wdata_i                  : EX/MEM memory-control bundle (held while stalled)
//   dmem                     : data-memory bus (master side)
//   stall_o                  : hold IF..EX/MEM
//   ld_data_o                : extended load result, valid from DONE
//   misalign_o               : misaligned-access trap, present only when
//                              LSU_MISALIGN_TRAP_EN is defined; otherwise the
//                              offending low address bits are forced to zero
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              synclr_i,
  input  logic              valid_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              mem_wren_i,
  input  logic [3:0]        byte_num_i,
  input  logic              ld_unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  mem_lsu_if.master         dmem,
  output logic              stall_o,
  output logic [DATA_W-1:0] ld_data_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_e  state_q, state_d;
  logic        mem_op, mis, req, capture;
  logic [1:0]  off_eff, off_q, st_off;
  logic [3:0]  bn_q, st_bn, be_raw;
  logic        uns_q, we_q;
  logic [31:0] lane_wdata, ld_ext;
  logic [DATA_W-1:0] ld_q;

  assign mem_op  = valid_i && (mem_wren_i || (wb_sel_i == WB_SEL_LOAD));
  assign off_eff = align_off(byte_num_i, addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis        = mem_op && is_misaligned(byte_num_i, addr_i[1:0]);
  assign misalign_o = mis_q;
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall_o = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (mem_op) begin
        stall_o = 1'b1;
        if (mis) state_d = DONE;
        else begin
          req = 1'b1;
          if (dmem.gnt) state_d = mem_wren_i ? DONE : WAIT;
          else          state_d = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        req     = 1'b1;
        if (dmem.gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem.rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue cycle uses the live bundle; REQ uses the copy latched at issue.
  assign st_bn  = (state_q == IDLE) ? byte_num_i : bn_q;
  assign st_off = (state_q == IDLE) ? off_eff    : off_q;

  mem_lsu_align u_align (
    .st_byte_num (st_bn),
    .st_off      (st_off),
    .st_wdata    (wdata_i[31:0]),
    .be          (be_raw),
    .lane_wdata  (lane_wdata),
    .ld_byte_num (bn_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (dmem.rdata),
    .ld_data     (ld_ext)
  );

  assign dmem.req   = req;
  assign dmem.we    = req && ((state_q == IDLE) ? mem_wren_i : we_q);
  assign dmem.be    = req ? be_raw : 4'b0000;
  assign dmem.addr  = {addr_i[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = lane_wdata;
  assign ld_data_o  = ld_q;

  always_ff @(posedge clk_i) begin
    if (synclr_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      bn_q    <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_op) begin
        off_q <= off_eff;
        bn_q  <= byte_num_i;
        uns_q <= ld_unsigned_i;
        we_q  <= mem_wren_i;
      end
      if (capture) ld_q <= ld_ext;
`ifdef LSU_MISALIGN_TRAP_EN
      // Trap flag lives exactly for the DONE cycle that follows detection.
      if (state_q == IDLE && mis) begin
        mis_q <= 1'b1;
        ld_q  <= '0;
      end else if (state_q == DONE) begin
        mis_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu. Acts as the data memory with
// configurable gnt/rvalid latency and checks bus lanes, stall length and load
// results against a byte-level reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        synclr;
  logic        valid;
  logic [1:0]  wb_sel;
  logic        mem_wren;
  logic [3:0]  byte_num;
  logic        ld_uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        mis_obs;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_ld;

  mem_lsu_if #(.ADDR_W(32)) dmem ();

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i         (clk),
    .synclr_i      (synclr),
    .valid_i       (valid),
    .wb_sel_i      (wb_sel),
    .mem_wren_i    (mem_wren),
    .byte_num_i    (byte_num),
    .ld_unsigned_i (ld_uns),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .dmem          (dmem.master),
    .stall_o       (stall),
    .ld_data_o     (ld_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o    (mis_obs)
`endif
  );

`ifndef LSU_MISALIGN_TRAP_EN
  assign mis_obs = 1'b0;
`endif

  typedef struct {
    int          cycles;
    int          req_cnt;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] ld;
    logic        we;
    logic        stable;
    logic        mis;
    logic        req_in_done;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [3:0] bn);
    if (bn == 4'b0001) return 1;
    if (bn == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [3:0] bn, input logic [31:0] a);
    int off = a % 4;
    if (m_size(bn) == 2) off = off - (off % 2);
    if (m_size(bn) == 4) off = 0;
    return off;
  endfunction

  function automatic logic m_mis(input logic [3:0] bn, input logic [31:0] a);
    return (m_size(bn) == 2 && (a % 2) != 0) || (m_size(bn) == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] bn, input logic [31:0] a);
    logic [3:0] r = 4'b0000;
    int off = m_off(bn, a);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + m_size(bn)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] bn, input logic [31:0] wd);
    if (m_size(bn) == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (m_size(bn) == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [3:0] bn, input logic uns,
                                       input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * m_off(bn, a));
    if (m_size(bn) == 1) begin
      v = v & 32'h000000FF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (m_size(bn) == 2) begin
      v = v & 32'h0000FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic go_idle();
    valid = 1'b0; mem_wren = 1'b0; wb_sel = 2'b00;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
  endtask

  // Presents one op and plays the memory side; returns what the bus showed.
  // Leaves the op on the inputs at the cycle after DONE so ops can run back to back.
  task automatic run_op(input logic we, input logic [3:0] bn, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gdly, input int rdly, output obs_t o);
    int   rq = 0;
    int   wc = 0;
    logic granted = 1'b0;
    o = '{default: 0};
    o.stable = 1'b1;
    valid = 1'b1; mem_wren = we; wb_sel = we ? 2'b00 : 2'b01;
    byte_num = bn; ld_uns = uns; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 60; cyc++) begin
      dmem.gnt    = !granted && (rq == gdly);
      dmem.rvalid = granted && !we && (wc == rdly);
      dmem.rdata  = dmem.rvalid ? rd : $urandom;
      @(negedge clk);
      if (!stall) begin
        o.cycles      = cyc + 1;
        o.ld          = ld_data;
        o.mis         = mis_obs;
        o.req_in_done = dmem.req;
        break;
      end
      if (dmem.req) begin
        if (rq == 0) begin
          o.be = dmem.be; o.wdata = dmem.wdata; o.addr = dmem.addr; o.we = dmem.we;
        end else if (o.be !== dmem.be || o.wdata !== dmem.wdata ||
                     o.addr !== dmem.addr || o.we !== dmem.we) begin
          o.stable = 1'b0;
        end
        rq++;
      end
      if (granted) wc++;
      if (dmem.req && dmem.gnt) granted = 1'b1;
      @(posedge clk); #1;
    end
    o.req_cnt = rq;
    @(posedge clk); #1;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    go_idle();
    synclr = 1'b1; byte_num = 4'b0001; ld_uns = 1'b0; addr = '0; wdata = '0; dmem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({dmem.req, dmem.we, dmem.be, stall, mis_obs} !== 8'h00 || ld_data !== 32'h0) begin
      errors++;
      $display("FAIL reset: req=%b we=%b be=%b stall=%b mis=%b ld=%h required all zero",
               dmem.req, dmem.we, dmem.be, stall, mis_obs, ld_data);
    end
    @(posedge clk); #1;
    synclr = 1'b0;
    last_ld = 32'h0;
  endtask

  task automatic test_lw_zero_wait();
    obs_t o;
    run_op(1'b0, 4'b1111, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, o);
    go_idle();
    checks++;
    if (o.cycles !== 3 || o.req_cnt !== 1) begin
      errors++; $display("FAIL lw_timing: cycles=%0d req=%0d required 3/1", o.cycles, o.req_cnt);
    end
    checks++;
    if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: addr=%h be=%b we=%b required 100/1111/0", o.addr, o.be, o.we);
    end
    checks++;
    if (o.ld !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h required deadbeef", o.ld);
    end
    last_ld = 32'hDEADBEEF;
  endtask

  task automatic test_lb_sign();
    obs_t o;
    run_op(1'b0, 4'b0001, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 0, o);
    checks++;
    if (o.be !== 4'b1000 || o.ld !== 32'hFFFFFF80 || o.addr !== 32'h100) begin
      errors++; $display("FAIL lb: be=%b ld=%h addr=%h required 1000/ffffff80/100", o.be, o.ld, o.addr);
    end
    run_op(1'b0, 4'b0001, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 0, o);
    go_idle();
    checks++;
    if (o.ld !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got %h required 00000080", o.ld);
    end
    last_ld = 32'h00000080;
  endtask

  task automatic test_sh_gnt_delay();
    obs_t o;
    run_op(1'b1, 4'b0011, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 3, 0, o);
    go_idle();
    checks++;
    if (o.req_cnt !== 4 || o.stable !== 1'b1 || o.cycles !== 5) begin
      errors++; $display("FAIL sh_hold: req_cycles=%0d stable=%b cycles=%0d required 4/1/5",
                         o.req_cnt, o.stable, o.cycles);
    end
    checks++;
    if (o.be !== 4'b1100 || o.wdata !== 32'hABCDABCD || o.we !== 1'b1) begin
      errors++; $display("FAIL sh_lanes: be=%b wdata=%h we=%b required 1100/abcdabcd/1", o.be, o.wdata, o.we);
    end
    checks++;
    if (ld_data !== last_ld) begin
      errors++; $display("FAIL sh_ld_keep: got %h required %h", ld_data, last_ld);
    end
  endtask

  task automatic test_stray_rvalid();
    obs_t o;
    dmem.rvalid = 1'b1; dmem.rdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_data !== last_ld || stall !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid: ld=%h stall=%b required %h/0", ld_data, stall, last_ld);
    end
    @(posedge clk); #1;
    run_op(1'b0, 4'b1111, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 0, 2, o);
    go_idle();
    checks++;
    if (o.cycles !== 5 || o.ld !== 32'hCAFEF00D) begin
      errors++; $display("FAIL lw_rvalid_delay: cycles=%0d ld=%h required 5/cafef00d", o.cycles, o.ld);
    end
    last_ld = 32'hCAFEF00D;
  endtask

  task automatic test_reset_mid_wait();
    valid = 1'b1; mem_wren = 1'b0; wb_sel = 2'b01; byte_num = 4'b1111; addr = 32'h300;
    dmem.gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL rst_wait_issue: req=%b stall=%b required 1/1", dmem.req, stall);
    end
    @(posedge clk); #1;
    dmem.gnt = 1'b0; synclr = 1'b1;
    @(posedge clk); #1;
    synclr = 1'b0; valid = 1'b0; wb_sel = 2'b00;
    dmem.rvalid = 1'b1; dmem.rdata = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem.req !== 1'b0 || ld_data !== 32'h0) begin
      errors++; $display("FAIL rst_wait: stall=%b req=%b ld=%h required 0/0/0", stall, dmem.req, ld_data);
    end
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_data !== 32'h0) begin
      errors++; $display("FAIL rst_late_rvalid: ld=%h required 0", ld_data);
    end
    @(posedge clk); #1;
    last_ld = 32'h0;
  endtask

  task automatic test_non_mem();
    valid = 1'b1; wb_sel = 2'b10; mem_wren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || dmem.req !== 1'b0) begin
        errors++; $display("FAIL non_mem: stall=%b req=%b required 0/0", stall, dmem.req);
      end
      @(posedge clk); #1;
    end
    go_idle();
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(1'b0, 4'b1111, 1'b0, 32'h102, 32'h0, 32'h11223344, 0, 0, o);
    go_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (o.cycles !== 2 || o.req_cnt !== 0 || o.mis !== 1'b1 || o.ld !== 32'h0) begin
      errors++; $display("FAIL misalign_trap: cycles=%0d req=%0d mis=%b ld=%h required 2/0/1/0",
                         o.cycles, o.req_cnt, o.mis, o.ld);
    end
    @(negedge clk);
    checks++;
    if (mis_obs !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: mis=%b required 0 after DONE", mis_obs);
    end
    @(posedge clk); #1;
    last_ld = 32'h0;
`else
    checks++;
    if (o.cycles !== 3 || o.addr !== 32'h100 || o.be !== 4'hF || o.ld !== 32'h11223344) begin
      errors++; $display("FAIL misalign_force: cycles=%0d addr=%h be=%b ld=%h required 3/100/1111/11223344",
                         o.cycles, o.addr, o.be, o.ld);
    end
    last_ld = 32'h11223344;
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic        we, uns, trap;
    logic [3:0]  bn;
    logic [31:0] a, wd, rd;
    int          gd, rdl, exp_cyc, exp_req;
    logic [31:0] exp_ld;
    for (int n = 0; n < 40; n++) begin
      we  = $urandom_range(0, 1) == 1;
      uns = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: bn = 4'b0001;
        1: bn = 4'b0011;
        default: bn = 4'b1111;
      endcase
      a = $urandom; wd = $urandom; rd = $urandom;
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = m_mis(bn, a);
`else
      trap = 1'b0;
`endif
      run_op(we, bn, uns, a, wd, rd, gd, rdl, o);
      exp_cyc = trap ? 2 : (2 + gd + (we ? 0 : 1 + rdl));
      exp_req = trap ? 0 : gd + 1;
      exp_ld  = trap ? 32'h0 : (we ? last_ld : m_ld(bn, uns, a, rd));
      checks++;
      if (o.cycles !== exp_cyc || o.req_cnt !== exp_req || o.stable !== 1'b1 || o.req_in_done !== 1'b0) begin
        errors++; $display("FAIL rand_timing[%0d]: cycles=%0d req=%0d stable=%b done_req=%b required %0d/%0d/1/0",
                           n, o.cycles, o.req_cnt, o.stable, o.req_in_done, exp_cyc, exp_req);
      end
      checks++;
      if (o.ld !== exp_ld || o.mis !== trap) begin
        errors++; $display("FAIL rand_ld[%0d]: ld=%h mis=%b required %h/%b", n, o.ld, o.mis, exp_ld, trap);
      end
      if (!trap) begin
        checks++;
        if (o.be !== m_be(bn, a) || o.addr !== {a[31:2], 2'b00} || o.we !== we ||
            (we && o.wdata !== m_wdata(bn, wd))) begin
          errors++; $display("FAIL rand_bus[%0d]: be=%b addr=%h we=%b wdata=%h required %b/%h/%b/%h",
                             n, o.be, o.addr, o.we, o.wdata, m_be(bn, a), {a[31:2], 2'b00}, we, m_wdata(bn, wd));
        end
      end
      last_ld = exp_ld;
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_lb_sign();
    test_sh_gnt_delay();
    test_stray_rvalid();
    test_reset_mid_wait();
    test_non_mem();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
